// File: rtl/ad782x_pkg.sv
// Shared types and default timing for the AD7822/AD7825 conversion controller.
package ad782x_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CH_W   = 2;

    localparam int unsigned ADDR_SETUP_CYC_DEF   = 2;
    localparam int unsigned CONVST_LOW_CYC_DEF   = 4;
    localparam int unsigned CONV_TIMEOUT_CYC_DEF = 200;
    localparam int unsigned RD_ACCESS_CYC_DEF    = 4;
    localparam int unsigned QUIET_CYC_DEF        = 50;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ADDR_SETUP = 3'd1,
        CONV_PULSE = 3'd2,
        WAIT_EOC   = 3'd3,
        READ       = 3'd4,
        QUIET      = 3'd5
    } state_e;

    // One captured sample together with the mux channel it came from.
    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } sample_t;

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single level, with a selectable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ad782x_conv_ctrl.sv
// Single-conversion controller for the AD7822/AD7825: address setup, CONVST pulse,
// EOC wait with timeout, CS/RD parallel read and a post-conversion quiet period.
module ad782x_conv_ctrl
    import ad782x_pkg::*;
#(
    parameter int unsigned ADDR_SETUP_CYC   = ADDR_SETUP_CYC_DEF,
    parameter int unsigned CONVST_LOW_CYC   = CONVST_LOW_CYC_DEF,
    parameter int unsigned CONV_TIMEOUT_CYC = CONV_TIMEOUT_CYC_DEF,
    parameter int unsigned RD_ACCESS_CYC    = RD_ACCESS_CYC_DEF,
    parameter int unsigned QUIET_CYC        = QUIET_CYC_DEF
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              adc_ready,
    input  logic              start,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic              EOC_n,
    input  logic [DATA_W-1:0] db_in,
    output logic              CONVST_n,
    output logic              CS_n,
    output logic              RD_n,
    output logic [CH_W-1:0]   A,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic [CH_W-1:0]   data_ch,
    output logic              data_valid,
    output logic              timeout_err
);

    localparam int unsigned CNT_MAX = umax(umax(umax(ADDR_SETUP_CYC, CONVST_LOW_CYC),
                                                umax(CONV_TIMEOUT_CYC, RD_ACCESS_CYC)),
                                           QUIET_CYC);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] ADDR_LAST    = CNT_W'(ADDR_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] CONV_LAST    = CNT_W'(CONVST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(CONV_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LAST      = CNT_W'(RD_ACCESS_CYC - 1);
    localparam logic [CNT_W-1:0] QUIET_LAST   = CNT_W'(QUIET_CYC - 1);

    state_e            state;
    state_e            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic [CH_W-1:0]   a_nxt;
    logic              convst_n_nxt;
    logic              cs_n_nxt;
    logic              rd_n_nxt;
    logic              data_valid_nxt;
    logic              timeout_nxt;
    sample_t           sample_q;
    sample_t           sample_nxt;
    logic              ready_s;
    logic              eoc_s;
    logic              eoc_prev;
    logic              eoc_fall_c;

    sync_2ff #(.RST_VAL(1'b0)) u_ready_sync (
        .clk   (clk_100MHz),
        .reset (reset),
        .d     (adc_ready),
        .q     (ready_s)
    );

    // EOC_n idles high, so its synchroniser resets high to avoid a false edge.
    sync_2ff #(.RST_VAL(1'b1)) u_eoc_sync (
        .clk   (clk_100MHz),
        .reset (reset),
        .d     (EOC_n),
        .q     (eoc_s)
    );

    assign eoc_fall_c = eoc_prev & ~eoc_s;
    assign cnt_inc_c  = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);

    assign data_out = sample_q.data;
    assign data_ch  = sample_q.ch;

    // Next-state and next-output decode; bus strobes default to inactive.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt_inc_c;
        a_nxt          = A;
        convst_n_nxt   = 1'b1;
        cs_n_nxt       = 1'b1;
        rd_n_nxt       = 1'b1;
        sample_nxt     = sample_q;
        data_valid_nxt = 1'b0;
        timeout_nxt    = 1'b0;

        if ((state != IDLE) && !ready_s) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    if (start && ready_s) begin
                        a_nxt     = ch_sel;
                        state_nxt = ADDR_SETUP;
                    end
                end
                ADDR_SETUP: begin
                    if (cnt == ADDR_LAST) begin
                        state_nxt    = CONV_PULSE;
                        cnt_nxt      = '0;
                        convst_n_nxt = 1'b0;
                    end
                end
                CONV_PULSE: begin
                    if (cnt == CONV_LAST) begin
                        state_nxt = WAIT_EOC;
                        cnt_nxt   = '0;
                    end else begin
                        convst_n_nxt = 1'b0;
                    end
                end
                WAIT_EOC: begin
                    if (eoc_fall_c) begin
                        state_nxt = READ;
                        cnt_nxt   = '0;
                        cs_n_nxt  = 1'b0;
                        rd_n_nxt  = 1'b0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state_nxt   = QUIET;
                        cnt_nxt     = '0;
                        timeout_nxt = 1'b1;
                    end
                end
                READ: begin
                    if (cnt == RD_LAST) begin
                        state_nxt       = QUIET;
                        cnt_nxt         = '0;
                        sample_nxt.data = db_in;
                        sample_nxt.ch   = A;
                        data_valid_nxt  = 1'b1;
                    end else begin
                        cs_n_nxt = 1'b0;
                        rd_n_nxt = 1'b0;
                    end
                end
                QUIET: begin
                    if (cnt == QUIET_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            A           <= '0;
            CONVST_n    <= 1'b1;
            CS_n        <= 1'b1;
            RD_n        <= 1'b1;
            busy        <= 1'b0;
            sample_q    <= '0;
            data_valid  <= 1'b0;
            timeout_err <= 1'b0;
            eoc_prev    <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            A           <= a_nxt;
            CONVST_n    <= convst_n_nxt;
            CS_n        <= cs_n_nxt;
            RD_n        <= rd_n_nxt;
            busy        <= (state_nxt != IDLE);
            sample_q    <= sample_nxt;
            data_valid  <= data_valid_nxt;
            timeout_err <= timeout_nxt;
            eoc_prev    <= eoc_s;
        end
    end

endmodule

// File: tb/tb_ad782x_conv_ctrl.sv
// Directed bench for ad782x_conv_ctrl with an inline ADC EOC model driven from the stimulus.
module tb_ad782x_conv_ctrl;

    logic       clk_100MHz;
    logic       reset;
    logic       adc_ready;
    logic       start;
    logic [1:0] ch_sel;
    logic       EOC_n;
    logic [7:0] db_in;
    logic       CONVST_n;
    logic       CS_n;
    logic       RD_n;
    logic [1:0] A;
    logic       busy;
    logic [7:0] data_out;
    logic [1:0] data_ch;
    logic       data_valid;
    logic       timeout_err;

    ad782x_conv_ctrl dut (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .adc_ready   (adc_ready),
        .start       (start),
        .ch_sel      (ch_sel),
        .EOC_n       (EOC_n),
        .db_in       (db_in),
        .CONVST_n    (CONVST_n),
        .CS_n        (CS_n),
        .RD_n        (RD_n),
        .A           (A),
        .busy        (busy),
        .data_out    (data_out),
        .data_ch     (data_ch),
        .data_valid  (data_valid),
        .timeout_err (timeout_err)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int eoc_at  = -1;
    int eoc_rel = -1;

    // Statistics gathered by observe()
    int n_cf, n_valid, n_to, n_bf, n_br;
    int cv_low, cs_low, rd_low;
    int t_cf, t_cr, t_csr, t_to, t_bf, t_bf1, t_ach;
    logic [7:0] v_data;
    logic [1:0] v_ch;
    logic [1:0] a_at_cf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; EOC_n pulses are scheduled against the absolute cycle count.
    task automatic tick();
        @(posedge clk_100MHz);
        #1;
        cyc++;
        if (cyc == eoc_at)  EOC_n = 1'b0;
        if (cyc == eoc_rel) EOC_n = 1'b1;
    endtask

    task automatic observe(input int n, input bit eoc_en, input bit hold_start,
                           input bit quiet_eoc, input bit stop_on_read);
        logic p_cv, p_cs, p_busy;
        logic [1:0] p_a;
        p_cv = CONVST_n; p_cs = CS_n; p_busy = busy; p_a = A;
        n_cf = 0; n_valid = 0; n_to = 0; n_bf = 0; n_br = 0;
        cv_low = 0; cs_low = 0; rd_low = 0;
        t_cf = -1; t_cr = -1; t_csr = -1; t_to = -1; t_bf = -1; t_bf1 = -1; t_ach = -1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == 0 && !hold_start) start = 1'b0;
            if (A != p_a) t_ach = cyc;
            if (!CONVST_n) cv_low++;
            if (p_cv && !CONVST_n) begin
                n_cf++;
                t_cf = cyc;
                a_at_cf = A;
                if (eoc_en) begin
                    eoc_at  = cyc + 42;
                    eoc_rel = cyc + 45;
                end
            end
            if (!p_cv && CONVST_n) t_cr = cyc;
            if (!CS_n) cs_low++;
            if (!RD_n) rd_low++;
            if (!p_cs && CS_n) begin
                t_csr = cyc;
                if (quiet_eoc) begin
                    eoc_at  = cyc + 10;
                    eoc_rel = cyc + 13;
                end
            end
            if (data_valid) begin
                n_valid++;
                v_data = data_out;
                v_ch   = data_ch;
            end
            if (timeout_err) begin
                n_to++;
                t_to = cyc;
            end
            if (p_busy && !busy) begin
                n_bf++;
                t_bf = cyc;
                if (n_bf == 1) t_bf1 = cyc;
            end
            if (!p_busy && busy) n_br++;
            p_cv = CONVST_n; p_cs = CS_n; p_busy = busy; p_a = A;
            if (stop_on_read && !CS_n) break;
        end
    endtask

    initial begin
        reset = 1'b1; adc_ready = 1'b0; start = 1'b0; ch_sel = 2'd0;
        EOC_n = 1'b1; db_in = 8'h00;
        tick(); tick(); tick();
        chk("rst_convst", 32'(CONVST_n), 32'd1);
        chk("rst_cs", 32'(CS_n), 32'd1);
        chk("rst_rd", 32'(RD_n), 32'd1);
        chk("rst_a", 32'(A), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_to", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        tick();

        // Start while the ADC is not ready: ignored
        ch_sel = 2'd2; start = 1'b1;
        observe(20, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("nrdy_busy", 32'(n_br), 32'd0);
        chk("nrdy_convst", 32'(cv_low), 32'd0);
        chk("nrdy_valid", 32'(n_valid), 32'd0);

        // Normal conversion on channel 3
        adc_ready = 1'b1;
        tick(); tick(); tick();
        ch_sel = 2'd3; db_in = 8'hA5; start = 1'b1;
        observe(400, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("conv_a_at_fall", 32'(a_at_cf), 32'd3);
        chk("conv_a_setup", 32'((t_cf - t_ach) >= 2), 32'd1);
        chk("conv_convst_low", 32'(cv_low), 32'd4);
        chk("conv_convst_rise", 32'(t_cr - t_cf), 32'd4);
        chk("conv_cs_low", 32'(cs_low), 32'd4);
        chk("conv_rd_low", 32'(rd_low), 32'd4);
        chk("conv_valid_cnt", 32'(n_valid), 32'd1);
        chk("conv_data", 32'(v_data), 32'hA5);
        chk("conv_ch", 32'(v_ch), 32'd3);
        chk("conv_quiet", 32'(t_bf - t_csr), 32'd50);
        chk("conv_no_to", 32'(n_to), 32'd0);
        chk("conv_busy_end", 32'(busy), 32'd0);

        // EOC never arrives: timeout
        ch_sel = 2'd1; db_in = 8'h11; start = 1'b1;
        observe(400, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("to_cnt", 32'(n_to), 32'd1);
        chk("to_time", 32'(t_to - t_cr), 32'd200);
        chk("to_no_valid", 32'(n_valid), 32'd0);
        chk("to_data_kept", 32'(data_out), 32'hA5);
        chk("to_quiet", 32'(t_bf - t_to), 32'd50);
        chk("to_busy_end", 32'(busy), 32'd0);

        // start held high throughout; EOC pulse injected during QUIET
        ch_sel = 2'd1; db_in = 8'h3C; start = 1'b1;
        observe(130, 1'b1, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        chk("ham_conv_cnt", 32'(n_cf), 32'd2);
        chk("ham_valid_cnt", 32'(n_valid), 32'd1);
        chk("ham_cs_low", 32'(cs_low), 32'd4);
        chk("ham_busy_fall", 32'(n_bf), 32'd1);
        chk("ham_restart", 32'(t_cf - t_bf1), 32'd3);
        chk("ham_data", 32'(v_data), 32'h3C);
        observe(100, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ham2_valid_cnt", 32'(n_valid), 32'd1);
        chk("ham2_data", 32'(v_data), 32'h3C);
        chk("ham2_ch", 32'(v_ch), 32'd1);
        chk("ham2_no_conv", 32'(n_cf), 32'd0);
        chk("ham2_busy_fall", 32'(n_bf), 32'd1);

        // adc_ready dropped in WAIT_EOC: abort
        ch_sel = 2'd2; db_in = 8'h77; start = 1'b1;
        observe(20, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        adc_ready = 1'b0;
        tick(); tick(); tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_convst", 32'(CONVST_n), 32'd1);
        chk("abort_cs", 32'(CS_n), 32'd1);
        chk("abort_rd", 32'(RD_n), 32'd1);
        observe(250, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_no_valid", 32'(n_valid), 32'd0);
        chk("abort_no_to", 32'(n_to), 32'd0);
        chk("abort_no_busy", 32'(n_br), 32'd0);
        chk("abort_data_kept", 32'(data_out), 32'h3C);

        // Reset asserted during READ
        adc_ready = 1'b1;
        tick(); tick(); tick();
        ch_sel = 2'd2; db_in = 8'hC3; start = 1'b1;
        observe(200, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rd_reached", 32'(CS_n), 32'd0);
        EOC_n = 1'b1; eoc_at = -1; eoc_rel = -1;
        reset = 1'b1;
        tick();
        chk("midrst_convst", 32'(CONVST_n), 32'd1);
        chk("midrst_cs", 32'(CS_n), 32'd1);
        chk("midrst_rd", 32'(RD_n), 32'd1);
        chk("midrst_a", 32'(A), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_data", 32'(data_out), 32'd0);
        chk("midrst_ch", 32'(data_ch), 32'd0);
        chk("midrst_valid", 32'(data_valid), 32'd0);
        chk("midrst_to", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        observe(60, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("postrst_no_valid", 32'(n_valid), 32'd0);
        chk("postrst_no_busy", 32'(n_br), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
